axi4_slave_write_data: RTL and testbench
========================================

Name: axi4_slave_write_data

Overview:
- AXI4 slave write-data stage, directly downstream of the write-address stage.
- Accepts one latched burst descriptor per transaction: address, ID, length, size and burst type.
- Consumes W-channel beats, generates the per-beat address, and drives a registered byte-enabled memory write port.
- Hands a response request (ID + BRESP) to the write-response stage.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, W data width in bits; power of 2, 8..1024.
- ID_WIDTH, 4, transaction ID width.
- BURST_LENGTH, 8, awlen width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- desc_valid  in  1  burst descriptor valid from the address stage.
- desc_ready  out  1  descriptor accepted when both desc_valid and desc_ready are high.
- desc_addr  in  ADDR_WIDTH  start address.
- desc_id  in  ID_WIDTH  transaction ID.
- desc_len  in  BURST_LENGTH  beats minus 1.
- desc_size  in  3  bytes per beat = 1<<desc_size.
- desc_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- wvalid  in  1  W beat valid.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wlast  in  1  last beat marker.
- wready  out  1  W beat accepted.
- mem_we  out  1  memory write enable, one cycle per beat.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_wdata  out  DATA_WIDTH  beat data.
- mem_wstrb  out  DATA_WIDTH/8  beat strobes.
- b_valid  out  1  response request to the B stage.
- b_ready  in  1  B stage accepts the response.
- b_id  out  ID_WIDTH  response ID.
- b_resp  out  2  00 OKAY, 10 SLVERR.

Behaviour:
- **Reset** (rst low, asynchronous): state W_IDLE. desc_ready=0, wready=0, mem_we=0, b_valid=0. mem_addr, mem_wdata, mem_wstrb, b_id, b_resp all 0. Internal counter, address and error flag cleared. Reset mid-burst abandons the burst with no response.
- **FSM states:** W_IDLE, W_DATA, W_RESP. All outputs are registered.
- **W_IDLE:** desc_ready=1, wready=0. On descriptor handshake:
  - Latch addr, id, len (as beat counter), size and burst.
  - Clear the error flag; go to W_DATA.
  - desc_ready drops the next cycle.
- **W_DATA:** wready=1, desc_ready=0. On each beat handshake (wvalid && wready):
  - Next cycle: mem_we=1, mem_addr=current address, mem_wdata/mem_wstrb=captured beat. Otherwise mem_we=0.
  - Then advance the address and decrement the counter.
  - Beat with counter==0 is the final beat: wready goes low the next cycle and the FSM goes to W_RESP.
- **Address update,** with B=1<<size and A=address aligned down to B:
  - FIXED: address unchanged.
  - INCR: next = A + B. The first beat may be unaligned; later beats are aligned. Carry beyond ADDR_WIDTH wraps modulo 2^ADDR_WIDTH.
  - WRAP: span W=(len+1)*B, lower = addr & ~(W-1). next = A + B; if next equals lower + W, next = lower.
  - Reserved (11): address held as FIXED.
- **Error flag** sets, but the burst still runs to completion and memory writes still occur, on any of:
  - burst==11.
  - WRAP with len not in {1,3,7,15}; addresses then follow INCR.
  - B > DATA_WIDTH/8.
- **W_RESP:**
  - b_valid=1, b_id=latched ID, b_resp = 10 if the error flag is set, else 00.
  - Hold stable until b_ready. On b_valid && b_ready: b_valid=0 next cycle, go to W_IDLE.
  - b_ready already high on entry: handshake completes in the first W_RESP cycle.
- **Throughput:**
  - Descriptor-to-first-beat bubble: 1 cycle.
  - One beat per cycle in W_DATA.
  - Minimum descriptor-to-descriptor time: len+4 cycles with b_ready held high.
- **Beat-handshake corner cases:** wvalid low while wready is high is a stall with no state change. wdata, wstrb and wlast are sampled only on handshake.
- wstrb=0 beat: mem_we still pulses, with mem_wstrb=0.

Optional Feature:
- Macro AXI4_WDATA_WLAST_CHECK_EN.
- **Defined:** on each beat, wlast must equal (counter==0).
  - Mismatch sets the error flag, giving SLVERR.
  - Early wlast does not end the burst; termination is always counter-based.
- **Undefined:** wlast is ignored entirely; no error arises from it.

Test Plan:
1. **INCR:** descriptor addr=0x1002, len=3, size=2, INCR, id=5; 4 beats, wlast on the 4th → mem_addr 0x1002, 0x1004, 0x1008, 0x100C; b_id=5, b_resp=00.
2. **WRAP:** addr=0x1034, len=3, size=2, WRAP → mem_addr 0x1034, 0x1038, 0x103C, 0x1030; OKAY.
3. **FIXED with stall:** addr=0x200, len=2, FIXED, wvalid low 2 cycles between beats → three mem_we pulses, all at 0x200; no write during the stall.
4. **Invalid descriptors:**
   - WRAP with len=2 → addresses follow INCR, b_resp=10.
   - size=3 with DATA_WIDTH=32 → b_resp=10, all beats still written.
5. **wlast check:** with AXI4_WDATA_WLAST_CHECK_EN defined, wlast on beat 2 of a len=3 burst → 4 beats accepted, b_resp=10. With the macro undefined, the same stimulus gives b_resp=00.
6. **Backpressure and reset:**
   - b_ready held low 5 cycles → b_valid, b_id and b_resp stable, desc_ready=0 throughout.
   - rst low mid-burst → all outputs 0 immediately; state W_IDLE after release.

Source files
------------

// File: rtl/axi4_slave_write_data_if.sv
// Bus bundle between the AXI4 write-data stage, its address/W/B neighbours and the memory port.
// The slave modport is the write-data stage's view; master is the surrounding system's view.
interface axi4_slave_write_data_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ID_WIDTH     = 4,
   parameter int BURST_LENGTH = 8
) ();
   logic                      desc_valid;
   logic                      desc_ready;
   logic [ADDR_WIDTH-1:0]     desc_addr;
   logic [ID_WIDTH-1:0]       desc_id;
   logic [BURST_LENGTH-1:0]   desc_len;
   logic [2:0]                desc_size;
   logic [1:0]                desc_burst;
   logic                      wvalid;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wlast;
   logic                      wready;
   logic                      mem_we;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH/8-1:0]   mem_wstrb;
   logic                      b_valid;
   logic                      b_ready;
   logic [ID_WIDTH-1:0]       b_id;
   logic [1:0]                b_resp;

   modport slave (
      input  desc_valid, desc_addr, desc_id, desc_len, desc_size, desc_burst,
      input  wvalid, wdata, wstrb, wlast, b_ready,
      output desc_ready, wready, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output b_valid, b_id, b_resp
   );

   modport master (
      output desc_valid, desc_addr, desc_id, desc_len, desc_size, desc_burst,
      output wvalid, wdata, wstrb, wlast, b_ready,
      input  desc_ready, wready, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  b_valid, b_id, b_resp
   );
endinterface

// File: rtl/axi4_slave_write_data.sv
// AXI4 slave write-data stage: walks one burst descriptor, writes each W beat to memory, requests a B response.
// Optional macro AXI4_WDATA_WLAST_CHECK_EN: flags SLVERR when wlast disagrees with the beat counter.
module axi4_slave_write_data #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ID_WIDTH     = 4,
   parameter int BURST_LENGTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   axi4_slave_write_data_if.slave  bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int MAX_SIZE   = $clog2(STRB_WIDTH);
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} state_t;

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ID_WIDTH-1:0]     id_r;
   logic [BURST_LENGTH-1:0] len_r;
   logic [BURST_LENGTH-1:0] cnt_r;
   logic [2:0]              size_r;
   logic [1:0]              burst_r;
   logic                    err_r;
   logic                    desc_ready_r;
   logic                    wready_r;
   logic                    mem_we_r;
   logic [ADDR_WIDTH-1:0]   mem_addr_r;
   logic [DATA_WIDTH-1:0]   mem_wdata_r;
   logic [STRB_WIDTH-1:0]   mem_wstrb_r;
   logic                    b_valid_r;
   logic [ID_WIDTH-1:0]     b_id_r;
   logic [1:0]              b_resp_r;

   logic                    beat_s;
   logic                    wrap_len_ok_s;
   logic                    desc_err_s;
   logic [1:0]              desc_burst_eff_s;
   logic                    wlast_err_s;
   logic [ADDR_WIDTH-1:0]   next_addr_s;

   // Reserved bursts fall through to the default arm and hold the address like FIXED.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0]   addr,
      input logic [2:0]              size,
      input logic [1:0]              burst,
      input logic [BURST_LENGTH-1:0] len
   );
      logic [ADDR_WIDTH-1:0] bytes;
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] span;
      logic [ADDR_WIDTH-1:0] lower;
      bytes = ADDR_WIDTH'(1) << size;
      incr  = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
      span  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      lower = addr & ~(span - ADDR_WIDTH'(1));
      case (burst)
         BURST_INCR: next_addr = incr;
         BURST_WRAP: next_addr = (incr == lower + span) ? lower : incr;
         default:    next_addr = addr;
      endcase
   endfunction

   // Descriptor legality; an illegal WRAP length is remapped to INCR at latch time.
   always_comb begin
      wrap_len_ok_s    = (bus.desc_len == BURST_LENGTH'(1)) || (bus.desc_len == BURST_LENGTH'(3)) ||
                         (bus.desc_len == BURST_LENGTH'(7)) || (bus.desc_len == BURST_LENGTH'(15));
      desc_err_s       = (bus.desc_burst == 2'b11) || (bus.desc_size > 3'(MAX_SIZE)) ||
                         ((bus.desc_burst == BURST_WRAP) && !wrap_len_ok_s);
      desc_burst_eff_s = bus.desc_burst;
      if ((bus.desc_burst == BURST_WRAP) && !wrap_len_ok_s) begin
         desc_burst_eff_s = BURST_INCR;
      end else begin
         desc_burst_eff_s = bus.desc_burst;
      end
   end

`ifdef AXI4_WDATA_WLAST_CHECK_EN
   // wlast must coincide exactly with the counter reaching zero.
   always_comb begin
      wlast_err_s = bus.wlast != (cnt_r == {BURST_LENGTH{1'b0}});
   end
`else
   logic unused_wlast_s;
   // wlast carries no meaning here; termination is purely counter-based.
   always_comb begin
      unused_wlast_s = bus.wlast;
      wlast_err_s    = 1'b0;
   end
`endif

   // Beat handshake and the address the following beat will use.
   always_comb begin
      beat_s      = bus.wvalid && wready_r;
      next_addr_s = next_addr(addr_r, size_r, burst_r, len_r);
   end

   // Control FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= W_IDLE;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         id_r         <= {ID_WIDTH{1'b0}};
         len_r        <= {BURST_LENGTH{1'b0}};
         cnt_r        <= {BURST_LENGTH{1'b0}};
         size_r       <= 3'b000;
         burst_r      <= 2'b00;
         err_r        <= 1'b0;
         desc_ready_r <= 1'b0;
         wready_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r  <= {DATA_WIDTH{1'b0}};
         mem_wstrb_r  <= {STRB_WIDTH{1'b0}};
         b_valid_r    <= 1'b0;
         b_id_r       <= {ID_WIDTH{1'b0}};
         b_resp_r     <= 2'b00;
      end else begin
         case (state_r)
            W_IDLE: begin
               mem_we_r  <= 1'b0;
               b_valid_r <= 1'b0;
               if (bus.desc_valid && desc_ready_r) begin
                  addr_r       <= bus.desc_addr;
                  id_r         <= bus.desc_id;
                  len_r        <= bus.desc_len;
                  cnt_r        <= bus.desc_len;
                  size_r       <= bus.desc_size;
                  burst_r      <= desc_burst_eff_s;
                  err_r        <= desc_err_s;
                  desc_ready_r <= 1'b0;
                  wready_r     <= 1'b1;
                  state_r      <= W_DATA;
               end else begin
                  desc_ready_r <= 1'b1;
                  wready_r     <= 1'b0;
               end
            end
            W_DATA: begin
               desc_ready_r <= 1'b0;
               if (beat_s) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= addr_r;
                  mem_wdata_r <= bus.wdata;
                  mem_wstrb_r <= bus.wstrb;
                  addr_r      <= next_addr_s;
                  cnt_r       <= cnt_r - BURST_LENGTH'(1);
                  err_r       <= err_r | wlast_err_s;
                  if (cnt_r == {BURST_LENGTH{1'b0}}) begin
                     wready_r  <= 1'b0;
                     b_valid_r <= 1'b1;
                     b_id_r    <= id_r;
                     b_resp_r  <= (err_r | wlast_err_s) ? 2'b10 : 2'b00;
                     state_r   <= W_RESP;
                  end else begin
                     wready_r  <= 1'b1;
                  end
               end else begin
                  mem_we_r <= 1'b0;
               end
            end
            W_RESP: begin
               mem_we_r     <= 1'b0;
               wready_r     <= 1'b0;
               desc_ready_r <= 1'b0;
               if (b_valid_r && bus.b_ready) begin
                  b_valid_r <= 1'b0;
                  state_r   <= W_IDLE;
               end else begin
                  b_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= W_IDLE;
               desc_ready_r <= 1'b0;
               wready_r     <= 1'b0;
               mem_we_r     <= 1'b0;
               b_valid_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.desc_ready = desc_ready_r;
   assign bus.wready     = wready_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.mem_wstrb  = mem_wstrb_r;
   assign bus.b_valid    = b_valid_r;
   assign bus.b_id       = b_id_r;
   assign bus.b_resp     = b_resp_r;
endmodule

// File: tb/tb_axi4_slave_write_data.sv
// Scoreboard bench for axi4_slave_write_data: directed bursts plus random bursts against a behavioural model.
module tb_axi4_slave_write_data;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} beat_t;
   typedef struct {logic [3:0] id; logic [1:0] resp;} resp_t;
   beat_t beat_q[$];
   resp_t resp_q[$];

   axi4_slave_write_data_if bus ();
   axi4_slave_write_data dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   // Address of beat k from the AXI rules, stepping beat by beat with plain arithmetic.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int k, input int len,
                                             input int sz, input int bt);
      longint unsigned a, b, w, lower, n;
      bit wrap_ok;
      wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      a = start;
      b = longint'(1) << sz;
      w = longint'(len + 1) * b;
      lower = (longint'(start) / w) * w;
      for (int i = 0; i < k; i++) begin
         if (bt == 0 || bt == 3) begin
            n = a;
         end else begin
            n = (a / b) * b + b;
            if (bt == 2 && wrap_ok && n == lower + w) n = lower;
         end
         a = n & 64'hFFFF_FFFF;
      end
      return a[31:0];
   endfunction

   // Monitor: pops the scoreboard whenever the DUT writes memory or completes a response.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.mem_we) begin
            if (beat_q.size() == 0) begin
               total++; bad++;
               $display("FAIL mem_we_unexpected actual=1 required=0 addr=%0h", bus.mem_addr);
            end else begin
               beat_t e;
               e = beat_q.pop_front();
               check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
               check("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
               check("mem_wstrb", 64'(bus.mem_wstrb), 64'(e.strb));
            end
         end
         if (bus.b_valid && bus.b_ready) begin
            if (resp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected actual=1 required=0");
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               check("b_id", 64'(bus.b_id), 64'(r.id));
               check("b_resp", 64'(bus.b_resp), 64'(r.resp));
            end
         end
      end
   end

   // One complete transaction; call and return at #1 after a rising edge.
   task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input int len, input int sz,
                            input int bt, input int stall, input bit stall_rand, input int early_last,
                            input int bready_delay);
      bit err, wrap_ok;
      int n;
      resp_t r;
      wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      err = (bt == 3) || (bt == 2 && !wrap_ok) || (sz > 2);
`ifdef AXI4_WDATA_WLAST_CHECK_EN
      if (early_last >= 0 && early_last != len) err = 1'b1;
`endif
      r.id = id;
      r.resp = err ? 2'b10 : 2'b00;
      resp_q.push_back(r);
      bus.b_ready    = (bready_delay == 0);
      bus.desc_addr  = addr;
      bus.desc_id    = id;
      bus.desc_len   = 8'(len);
      bus.desc_size  = 3'(sz);
      bus.desc_burst = 2'(bt);
      bus.desc_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.desc_ready) break;
         if (++n > 50) begin fail_timeout("desc_ready_wait"); bus.desc_valid = 1'b0; return; end
      end
      @(posedge clk); #1;
      bus.desc_valid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         beat_t e;
         int s;
         s = stall_rand ? $urandom_range(0, stall) : ((k > 0) ? stall : 0);
         bus.wvalid = 1'b0;
         repeat (s) begin @(posedge clk); #1; end
         e.addr = beat_addr(addr, k, len, sz, bt);
         e.data = $urandom;
         e.strb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
         beat_q.push_back(e);
         bus.wdata  = e.data;
         bus.wstrb  = e.strb;
         bus.wlast  = (early_last >= 0) ? (k == early_last) : (k == len);
         bus.wvalid = 1'b1;
         n = 0;
         forever begin
            @(negedge clk);
            if (bus.wready) break;
            if (++n > 50) begin fail_timeout("wready_wait"); bus.wvalid = 1'b0; return; end
         end
         @(posedge clk); #1;
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      if (bready_delay > 0) begin
         n = 0;
         forever begin
            @(negedge clk);
            if (bus.b_valid) break;
            if (++n > 50) begin fail_timeout("b_valid_wait"); return; end
         end
         repeat (bready_delay) begin
            @(negedge clk);
            check("bp_b_valid", 64'(bus.b_valid), 64'd1);
            check("bp_b_id", 64'(bus.b_id), 64'(r.id));
            check("bp_b_resp", 64'(bus.b_resp), 64'(r.resp));
            check("bp_desc_ready", 64'(bus.desc_ready), 64'd0);
         end
         @(posedge clk); #1;
         bus.b_ready = 1'b1;
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.b_valid && bus.b_ready) break;
         if (++n > 50) begin fail_timeout("b_handshake_wait"); return; end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_desc_ready"}, 64'(bus.desc_ready), 64'd0);
      check({tag, "_wready"}, 64'(bus.wready), 64'd0);
      check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      check({tag, "_mem_wstrb"}, 64'(bus.mem_wstrb), 64'd0);
      check({tag, "_b_valid"}, 64'(bus.b_valid), 64'd0);
      check({tag, "_b_id"}, 64'(bus.b_id), 64'd0);
      check({tag, "_b_resp"}, 64'(bus.b_resp), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.desc_valid = 1'b0; bus.desc_addr = 32'h0; bus.desc_id = 4'h0; bus.desc_len = 8'h0;
      bus.desc_size = 3'h0; bus.desc_burst = 2'h0; bus.wvalid = 1'b0; bus.wdata = 32'h0;
      bus.wstrb = 4'h0; bus.wlast = 1'b0; bus.b_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_desc_ready", 64'(bus.desc_ready), 64'd1);
      check("idle_wready", 64'(bus.wready), 64'd0);

      run_burst(32'h1002, 4'd5, 3, 2, 1, 0, 1'b0, -1, 0);   // INCR, unaligned start
      run_burst(32'h1034, 4'd6, 3, 2, 2, 0, 1'b0, -1, 0);   // WRAP
      run_burst(32'h0200, 4'd7, 2, 2, 0, 2, 1'b0, -1, 0);   // FIXED with 2-cycle stalls
      run_burst(32'h1034, 4'd8, 2, 2, 2, 0, 1'b0, -1, 0);   // illegal WRAP length
      run_burst(32'h0400, 4'd9, 3, 3, 1, 0, 1'b0, -1, 0);   // size wider than the bus
      run_burst(32'h0500, 4'd10, 3, 2, 1, 0, 1'b0, 1, 0);   // wlast on beat 2
      run_burst(32'h0600, 4'd11, 1, 2, 3, 0, 1'b0, -1, 0);  // reserved burst type
      run_burst(32'hFFFF_FFF8, 4'd12, 3, 2, 1, 0, 1'b0, -1, 0); // address carry wraps
      run_burst(32'h0700, 4'd13, 1, 1, 1, 0, 1'b0, -1, 5);  // B backpressure

      // Reset in the middle of a burst abandons it without a response.
      bus.desc_addr = 32'h3000; bus.desc_id = 4'd3; bus.desc_len = 8'd7;
      bus.desc_size = 3'd2; bus.desc_burst = 2'b01; bus.desc_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.desc_ready) break;
         if (++n > 50) begin fail_timeout("rst_desc_wait"); break; end
      end
      @(posedge clk); #1;
      bus.desc_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         beat_t e;
         e.addr = 32'h3000 + 32'(k * 4); e.data = $urandom; e.strb = 4'hF;
         beat_q.push_back(e);
         bus.wdata = e.data; bus.wstrb = e.strb; bus.wlast = 1'b0; bus.wvalid = 1'b1;
         @(posedge clk); #1;
      end
      bus.wvalid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check_outputs_zero("midburst_rst");
      beat_q.delete();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_desc_ready", 64'(bus.desc_ready), 64'd1);
      check("post_rst_wready", 64'(bus.wready), 64'd0);
      run_burst(32'h0800, 4'd14, 1, 2, 1, 0, 1'b0, -1, 0);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
         run_burst(a, 4'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                   2, 1'b1, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end

      repeat (4) @(posedge clk);
      #1;
      check("beat_queue_empty", 64'(beat_q.size()), 64'd0);
      check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
